addsub_sequencer: RTL

Command-driven front end for the 8-bit add/subtract datapath: accepts one operation per valid/ready handshake, registers operands, and drives the adder's `x`, `y`, `mode` inputs. It then captures `sum`/`cout`, derives status flags, and holds the result until the consumer takes it. It also keeps an 8-bit running accumulator, so the adder can be used for accumulate sequences without external state.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_flags.sv | 50 +++++
 rtl/addsub_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the add/subtract command front end and
// any later arithmetic stage that reuses the flag logic.
//   ALU_W          : datapath width (8, matching the external adder)
//   OP_ADD..OP_ACC : 2-bit command op encodings
//   state_t        : sequencer FSM states
package alu_pkg;

  localparam int ALU_W = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_ACC = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_flags.sv
// alu_flags: purely combinational status flag generator for an add/subtract
// stage.
// Ports:
//   x, y   in  WIDTH : adder operands as presented to the adder
//   s      in  WIDTH : adder sum
//   cout   in  1     : adder carry-out (meaningful only when adding)
//   mode   in  1     : 1 = subtract (s = x - y), 0 = add
//   z      out 1     : result is zero
//   c      out 1     : carry (add) or unsigned borrow (subtract)
//   n      out 1     : result sign bit
//   v      out 1     : signed overflow
module alu_flags
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] s,
  input  logic             cout,
  input  logic             mode,
  output logic             z,
  output logic             c,
  output logic             n,
  output logic             v
);

  logic w_xs;
  logic w_ys;
  logic w_ss;

  assign w_xs = x[WIDTH-1];
  assign w_ys = y[WIDTH-1];
  assign w_ss = s[WIDTH-1];

  always_comb begin
    z = (s == '0);
    n = w_ss;
    if (mode) begin
      // The adder forces cout low when subtracting, so the borrow is
      // reconstructed from the operand and result sign bits.
      c = (~w_xs & w_ys) | (~(w_xs ^ w_ys) & w_ss);
      v = (w_xs != w_ys) & (w_ss != w_xs);
    end else begin
      c = cout;
      v = (w_xs == w_ys) & (w_ss != w_xs);
    end
  end

endmodule

// File: rtl/addsub_sequencer.sv
// addsub_sequencer: command-driven front end for an external 8-bit
// add/subtract datapath. Accepts one command per valid/ready handshake,
// registers the adder operands, captures the sum one cycle later, derives
// status flags and holds the result until the consumer takes it. Keeps a
// running accumulator updated by ADD, SUB and ACC (not CMP).
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready    : command handshake (ready only in IDLE)
//   cmd_op, cmd_a, cmd_b   : op (ADD/SUB/CMP/ACC) and operands
//   add_x, add_y, add_mode : registered drive to the external adder
//   add_sum, add_cout      : combinational adder result
//   res_valid/res_ready    : result handshake
//   res_data, flag_z/c/n/v : captured sum and status flags
//   acc_out                : current accumulator value
module addsub_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] add_x,
  output logic [WIDTH-1:0] add_y,
  output logic             add_mode,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic             flag_v,
  output logic [WIDTH-1:0] acc_out
);

  state_t           r_state;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic             r_mode;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_acc;
  logic             r_z;
  logic             r_c;
  logic             r_n;
  logic             r_v;

  logic w_z;
  logic w_c;
  logic w_n;
  logic w_v;

  // Flags are taken from the registered operands, i.e. exactly what the
  // adder saw, so ACC flags are relative to the old accumulator value.
  alu_flags #(
    .WIDTH(WIDTH)
  ) u_flags (
    .x    (r_x),
    .y    (r_y),
    .s    (add_sum),
    .cout (add_cout),
    .mode (r_mode),
    .z    (w_z),
    .c    (w_c),
    .n    (w_n),
    .v    (w_v)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_mode  <= 1'b0;
      r_op    <= OP_ADD;
      r_res   <= '0;
      r_acc   <= '0;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
      r_n     <= 1'b0;
      r_v     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_op <= cmd_op;
            case (cmd_op)
              OP_ADD: begin
                r_x    <= cmd_a;
                r_y    <= cmd_b;
                r_mode <= 1'b0;
              end
              OP_ACC: begin
                r_x    <= r_acc;
                r_y    <= cmd_a;
                r_mode <= 1'b0;
              end
              default: begin  // SUB and CMP
                r_x    <= cmd_a;
                r_y    <= cmd_b;
                r_mode <= 1'b1;
              end
            endcase
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_res <= add_sum;
          r_z   <= w_z;
          r_c   <= w_c;
          r_n   <= w_n;
          r_v   <= w_v;
          if (r_op != OP_CMP) begin
            r_acc <= add_sum;
          end
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (res_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign res_valid = (r_state == ST_DONE);
  assign add_x     = r_x;
  assign add_y     = r_y;
  assign add_mode  = r_mode;
  assign res_data  = r_res;
  assign flag_z    = r_z;
  assign flag_c    = r_c;
  assign flag_n    = r_n;
  assign flag_v    = r_v;
  assign acc_out   = r_acc;

endmodule
